// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the serial nibble adder: controller states and slice width.
package serial_adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Nibble index needs at least one bit even when only one slice would be addressed.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder_4bit.sv
// Combinational 4-bit adder slice shared by the serial controller.
module full_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/serial_adder_ctrl.sv
// Wide add/subtract by stepping one 4-bit slice across the operands, LS nibble first.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      sub,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                      cin,
  output logic                      busy,
  output logic                      done,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                      cout
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e              state;
  logic [W-1:0]        a_r;
  logic [W-1:0]        b_r;
  logic                carry;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W+1:0]    base;
  logic                accept;
  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;

  assign accept  = (state == IDLE) && start;
  assign base    = {idx, 2'b00};
  assign slice_a = a_r[base +: NIBBLE_W];
  assign slice_b = b_r[base +: NIBBLE_W];

  full_adder_4bit u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Operand capture; subtraction stores ~b so the slice computes a + ~b + 1.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= a;
      b_r <= sub ? ~b : b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
            sum   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sum[base +: NIBBLE_W] <= slice_sum;
          carry                 <= slice_cout;
          if (idx == LAST_IDX) begin
            cout  <= slice_cout;
            done  <= 1'b1;
            busy  <= 1'b0;
            idx   <= '0;
            state <= IDLE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at the default four-nibble width.
module tb_serial_adder_ctrl;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  serial_adder_ctrl #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start one operation, scramble inputs after acceptance, and check the full done timeline.
  task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic icin, input logic isub,
                        input logic [W-1:0] es, input logic ec);
    @(negedge clk);
    a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~ia; b = ib ^ 16'h5A5A; cin = ~icin; sub = ~isub;
    chk({tag, ".busy_e0"}, busy, 1);
    chk({tag, ".sum_clr"}, sum[3:0], 0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk({tag, ".early_done"}, {busy, done}, 2'b10);
    end
    @(negedge clk);
    chk({tag, ".done"}, {busy, done}, 2'b01);
    chk({tag, ".sum"}, sum, es);
    chk({tag, ".cout"}, cout, ec);
    @(negedge clk);
    chk({tag, ".pulse"}, {busy, done}, 2'b00);
    chk({tag, ".hold"}, {cout, sum}, {ec, es});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    chk("reset_outputs", {busy, done, cout, sum}, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add_3_5", 16'h0003, 16'h0005, 1'b0, 1'b0, 16'h0008, 1'b0);
    run_op("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_op("add_ffff_ffff_c", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1);
    run_op("sub_1234_0235", 16'h1234, 16'h0235, 1'b1, 1'b1, 16'h0FFF, 1'b1);
    run_op("sub_1_2", 16'h0001, 16'h0002, 1'b0, 1'b1, 16'hFFFF, 1'b0);

    // start pulse and operand change two cycles into RUN must be ignored
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a = 16'hAAAA; b = 16'h5555; sub = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) n_done++;
      if (done) chk("ignore_start.sum", sum, 16'h3333);
      @(negedge clk);
    end
    chk("ignore_start.ndone", n_done, 1);
    chk("ignore_start.idle", {busy, sum}, {1'b0, 16'h3333});

    // start held high: done at cycles 4 and 9 after the first acceptance
    @(negedge clk);
    a = 16'h0007; b = 16'h0009; cin = 1'b0; sub = 1'b0; start = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (k == 4) begin
        chk("b2b.done1", {busy, done}, 2'b01);
        chk("b2b.sum1", sum, 16'h0010);
        a = 16'h00FF; b = 16'h0001;
      end else if (k == 5) begin
        chk("b2b.accept2", {busy, done, sum}, {2'b10, 16'h0000});
      end else if (k == 9) begin
        chk("b2b.done2", {busy, done}, 2'b01);
        chk("b2b.sum2", sum, 16'h0100);
        start = 1'b0;
      end else begin
        chk("b2b.nodone", done, 0);
      end
    end
    @(negedge clk);
    chk("b2b.idle", {busy, done}, 2'b00);

    // leave cout=1 so the asynchronous reset visibly clears it
    run_op("pre_rst", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.sum_partial", sum[7:0], 8'h45);
    #2 rst = 1'b1;
    #1;
    chk("rst.async", {busy, done, cout, sum}, 0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    chk("rst.no_done", n_done, 0);
    run_op("post_rst", 16'h0003, 16'h0005, 1'b0, 1'b0, 16'h0008, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
